// File: rtl/fifo_rd_drain_pkg.sv
// Shared types for the FIFO read-side drain master.
//   DR_DATA_WIDTH  default FIFO word width
//   drain_state_e  drain FSM states (IDLE / RUN / STOP)
//   drain_word_t   one stream word: data plus end-of-burst tag
package fifo_rd_drain_pkg;

  localparam int DR_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    DR_IDLE = 2'd0,
    DR_RUN  = 2'd1,
    DR_STOP = 2'd2
  } drain_state_e;

  typedef struct packed {
    logic                     last;
    logic [DR_DATA_WIDTH-1:0] data;
  } drain_word_t;

endpackage

// File: rtl/fifo_rd_drain_skid2.sv
// Two-entry skid buffer holding {last, data} words between the FIFO read
// port and the output stream.
//   clk, rst     clock, asynchronous active-high reset
//   push_i       write push_data_i this cycle (caller guarantees room)
//   push_data_i  word to store
//   pop_i        head word consumed this cycle (only when occ_o != 0)
//   occ_o        number of stored words, 0..2
//   head_o       oldest stored word
module fifo_rd_drain_skid2 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [1:0]   occ_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] ent0_q;   // head
  logic [W-1:0] ent1_q;   // second entry, valid only when occ_q == 2
  logic [1:0]   occ_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (occ_q == 2'd0) ent0_q <= push_data_i;
          else               ent1_q <= push_data_i;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          ent0_q <= ent1_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new word goes behind whatever remains.
          if (occ_q == 2'd2) begin
            ent0_q <= ent1_q;
            ent1_q <= push_data_i;
          end else begin
            ent0_q <= push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign occ_o  = occ_q;
  assign head_o = ent0_q;

endmodule

// File: rtl/fifo_rd_drain.sv
// FIFO read-side drain master: pops the FIFO whenever it is non-empty and
// there is guaranteed room downstream, re-times the words onto a valid/ready
// stream through a 2-entry skid buffer and tags every BURST_LEN-th popped
// word with out_last.
//   clk, rst      clock, asynchronous active-high reset
//   enable        1 = drain; 0 = deliver in-flight/buffered words, then stop
//   fifo_empty    FIFO empty flag
//   fifo_rd_en    pop strobe (combinational)
//   fifo_rd_data  FIFO data, valid the cycle after fifo_rd_en
//   out_valid/out_ready/out_data/out_last   output stream
//   busy          FSM not idle, or words in flight / buffered
//   words_sent    accepted stream words, wraps
//   dbg_state     current drain_state_e encoding
//
// Stream handshake: a word transfers on a rising edge where out_valid and
// out_ready are both 1; while out_valid is 1 and out_ready is 0, out_data and
// out_last hold their value and out_valid stays 1.
module fifo_rd_drain
  import fifo_rd_drain_pkg::*;
#(
  parameter int DATA_WIDTH = DR_DATA_WIDTH,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  words_sent,
  output logic [1:0]            dbg_state
);

  localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  drain_state_e         state_q;
  logic                 inflight_q;       // popped last cycle, data arriving now
  logic                 inflight_last_q;  // burst tag of the in-flight word
  logic [BCW-1:0]       burst_cnt_q;
  logic [CNT_WIDTH-1:0] words_sent_q;

  logic [1:0]            skid_occ;
  logic [DATA_WIDTH:0]   skid_head;
  logic                  xfer;
  logic                  last_at_pop;
  logic [2:0]            committed;

  assign out_valid   = (skid_occ != 2'd0);
  assign xfer        = out_valid && out_ready;
  assign last_at_pop = (burst_cnt_q == BCW'(BURST_LEN - 1));

  // Words already owed to the skid (buffered + in flight), less the one
  // leaving this cycle. A new pop lands two edges from now, so it is safe
  // only while this stays below the skid depth. Crediting the departing word
  // is what sustains one word per cycle.
  assign committed  = {1'b0, skid_occ} + {2'b00, inflight_q};
  assign fifo_rd_en = (state_q == DR_RUN) && enable && !fifo_empty &&
                      (committed < (3'd2 + {2'b00, xfer}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= DR_IDLE;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      burst_cnt_q     <= '0;
      words_sent_q    <= '0;
    end else begin
      inflight_q <= fifo_rd_en;
      if (fifo_rd_en) begin
        inflight_last_q <= last_at_pop;
        burst_cnt_q     <= last_at_pop ? '0 : burst_cnt_q + BCW'(1);
      end
      if (xfer) words_sent_q <= words_sent_q + CNT_WIDTH'(1);

      case (state_q)
        DR_IDLE: if (enable) state_q <= DR_RUN;
        DR_RUN:  if (!enable) state_q <= DR_STOP;
        DR_STOP: begin
          if (enable)                                 state_q <= DR_RUN;
          else if (!inflight_q && skid_occ == 2'd0)   state_q <= DR_IDLE;
        end
        default: state_q <= DR_IDLE;
      endcase
    end
  end

  fifo_rd_drain_skid2 #(
    .W (DATA_WIDTH + 1)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i ({inflight_last_q, fifo_rd_data}),
    .pop_i       (xfer),
    .occ_o       (skid_occ),
    .head_o      (skid_head)
  );

  assign out_data   = skid_head[DATA_WIDTH-1:0];
  assign out_last   = out_valid && skid_head[DATA_WIDTH];
  assign busy       = (state_q != DR_IDLE) || inflight_q || (skid_occ != 2'd0);
  assign words_sent = words_sent_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fifo_rd_drain.sv
module tb_fifo_rd_drain;
  import fifo_rd_drain_pkg::*;

  localparam int DW = 8;
  localparam int BL = 4;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          enable;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic [CW-1:0] words_sent;
  logic [1:0]    dbg_state;

  fifo_rd_drain #(
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .words_sent   (words_sent),
    .dbg_state    (dbg_state)
  );

  // ---------------- FIFO model ----------------
  logic [DW-1:0] fifo_mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= fifo_mem[rd_ptr[7:0]];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW:0]   exp_q[$];
  int            exp_bcnt = 0;
  logic [CW-1:0] exp_sent = '0;
  int            n_pass = 0;
  int            n_total = 0;
  logic          stall_prev = 1'b0;
  logic [DW:0]   stall_word = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Loads a word into the FIFO model; the expected burst tag follows pop order.
  task automatic push_word(input logic [DW-1:0] d);
    fifo_mem[wr_ptr[7:0]] = d;
    wr_ptr++;
    exp_q.push_back({(exp_bcnt == BL - 1), d});
    exp_bcnt = (exp_bcnt + 1) % BL;
  endtask

  task automatic check_cycle();
    drain_word_t w;
    if (fifo_rd_en) chk("no_pop_on_empty", 32'(fifo_empty), 32'd0);
    if (stall_prev) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_hold", 32'({out_last, out_data}), 32'(stall_word));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL extra_word: got %0h, expected no word", {out_last, out_data});
      end else begin
        w = drain_word_t'(exp_q.pop_front());
        chk("stream_data", 32'(out_data), 32'(w.data));
        chk("stream_last", 32'(out_last), 32'(w.last));
        exp_sent = exp_sent + 1'b1;
      end
    end
    stall_prev = out_valid && !out_ready;
    stall_word = {out_last, out_data};
  endtask

  task automatic cyc();
    #1;
    check_cycle();
    @(negedge clk);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      cyc();
      n++;
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst, en, rdy;
    logic          rd_en, valid;
    logic [DW-1:0] data;
    logic          last, busy;
    logic [CW-1:0] sent;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(input logic r, e, y, rd, v, input logic [7:0] d,
                              input logic l, b, input logic [3:0] s);
    vec_t t;
    t.rst = r; t.en = e; t.rdy = y; t.rd_en = rd; t.valid = v;
    t.data = d; t.last = l; t.busy = b; t.sent = s;
    return t;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst en rdy rd  vld data  lst bsy sent
    tbl[0]  = mk(1, 1, 1,  0,  0,  8'h00, 0,  0,  4'd0);
    tbl[1]  = mk(1, 1, 1,  0,  0,  8'h00, 0,  0,  4'd0);
    tbl[2]  = mk(0, 1, 1,  0,  0,  8'h00, 0,  0,  4'd0);
    tbl[3]  = mk(0, 1, 1,  1,  0,  8'h00, 0,  1,  4'd0);
    tbl[4]  = mk(0, 1, 1,  1,  0,  8'h00, 0,  1,  4'd0);
    tbl[5]  = mk(0, 1, 1,  1,  1,  8'h10, 0,  1,  4'd0);
    tbl[6]  = mk(0, 1, 1,  1,  1,  8'h11, 0,  1,  4'd1);
    tbl[7]  = mk(0, 1, 1,  1,  1,  8'h12, 0,  1,  4'd2);
    tbl[8]  = mk(0, 1, 1,  1,  1,  8'h13, 1,  1,  4'd3);
    tbl[9]  = mk(0, 1, 1,  1,  1,  8'h14, 0,  1,  4'd4);
    tbl[10] = mk(0, 1, 1,  1,  1,  8'h15, 0,  1,  4'd5);
    tbl[11] = mk(0, 1, 1,  0,  1,  8'h16, 0,  1,  4'd6);
    tbl[12] = mk(0, 1, 1,  0,  1,  8'h17, 1,  1,  4'd7);
    tbl[13] = mk(0, 1, 1,  0,  0,  8'h00, 0,  1,  4'd8);

    rst = 1'b1;
    enable = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'(8'h10 + i));
    @(negedge clk);

    // Reset with a non-empty FIFO, then an 8-word stream.
    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst;
      enable = tbl[i].en;
      out_ready = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d_rd_en", i), 32'(fifo_rd_en), 32'(tbl[i].rd_en));
      chk($sformatf("row%0d_valid", i), 32'(out_valid), 32'(tbl[i].valid));
      if (tbl[i].valid || tbl[i].rst)
        chk($sformatf("row%0d_data", i), 32'(out_data), 32'(tbl[i].data));
      chk($sformatf("row%0d_last", i), 32'(out_last), 32'(tbl[i].last));
      chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("row%0d_sent", i), 32'(words_sent), 32'(tbl[i].sent));
      check_cycle();
      @(negedge clk);
    end

    // Backpressure: ready low for 5 cycles mid-stream.
    for (int i = 0; i < 8; i++) push_word(8'(8'h20 + i));
    repeat (4) cyc();
    out_ready = 1'b0;
    repeat (4) cyc();
    #1;
    chk("bp_no_pop_full", 32'(fifo_rd_en), 32'd0);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_head", 32'(out_data), 32'h22);
    check_cycle();
    @(negedge clk);
    out_ready = 1'b1;
    drain(40);
    chk("bp_sent_wrapped", 32'(words_sent), 32'd0);

    // FIFO runs empty mid-burst, refilled 3 cycles later.
    push_word(8'h30);
    push_word(8'h31);
    drain(20);
    repeat (3) cyc();
    push_word(8'h32);
    push_word(8'h33);
    push_word(8'h34);
    #1;
    chk("refill_pop", 32'(fifo_rd_en), 32'd1);
    chk("refill_lat0", 32'(out_valid), 32'd0);
    check_cycle();
    @(negedge clk);
    #1;
    chk("refill_lat1", 32'(out_valid), 32'd0);
    check_cycle();
    @(negedge clk);
    #1;
    chk("refill_lat2", 32'(out_valid), 32'd1);
    chk("refill_first", 32'(out_data), 32'h32);
    check_cycle();
    @(negedge clk);
    #1;
    chk("refill_4th_data", 32'(out_data), 32'h33);
    chk("refill_4th_last", 32'(out_last), 32'd1);
    check_cycle();
    @(negedge clk);
    drain(20);
    chk("refill_sent", 32'(words_sent), 32'd5);

    // Stop with one word in flight and one buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'(8'h40 + i));
    cyc();
    cyc();
    enable = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("stop_no_pop", 32'(fifo_rd_en), 32'd0);
    chk("stop_busy", 32'(busy), 32'd1);
    check_cycle();
    @(negedge clk);
    begin
      int n = 0;
      while (busy && n < 10) begin
        #1;
        chk("stop_drain_no_pop", 32'(fifo_rd_en), 32'd0);
        check_cycle();
        @(negedge clk);
        n++;
      end
    end
    #1;
    chk("stop_busy_low", 32'(busy), 32'd0);
    chk("stop_state_idle", 32'(dbg_state), 32'(DR_IDLE));
    chk("stop_idle_no_pop", 32'(fifo_rd_en), 32'd0);
    chk("stop_words_left", 32'(exp_q.size()), 32'd2);
    check_cycle();
    @(negedge clk);
    enable = 1'b1;
    drain(20);
    chk("resume_sent", 32'(words_sent), 32'd9);

    // Async reset mid-burst, then counter wrap.
    out_ready = 1'b0;
    push_word(8'h50);
    push_word(8'h51);
    repeat (3) cyc();
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    check_cycle();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_last", 32'(out_last), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_sent", 32'(words_sent), 32'd0);
    chk("arst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'(DR_IDLE));
    exp_q.delete();
    exp_bcnt = 0;
    exp_sent = '0;
    stall_prev = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) push_word(8'(8'h60 + i));
    #1;
    chk("rel_idle_no_pop", 32'(fifo_rd_en), 32'd0);
    check_cycle();
    @(negedge clk);
    #1;
    chk("rel_first_pop", 32'(fifo_rd_en), 32'd1);
    check_cycle();
    @(negedge clk);
    drain(60);
    chk("wrap_sent", 32'(words_sent), 32'd1);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
